// File: rtl/a2d_rr_scheduler.sv
// Round-robin A2D conversion scheduler: drives an SPI master through batt/curr/brake/torque.
// Latency: result registers, conv_vld and ch_id update one clk after the second-transaction done.
// Backpressure: none; one transaction outstanding, and a tick that lands mid-conversion is dropped as overrun.
module a2d_rr_scheduler #(
    parameter int PERIOD_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        snd,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        conv_vld,
    output logic [1:0]  ch_id,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q;
    logic                tick;
    logic [1:0]          ptr_q, ptr_d;
    logic                snd_q, snd_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [11:0]         batt_q, batt_d;
    logic [11:0]         curr_q, curr_d;
    logic [11:0]         brake_q, brake_d;
    logic [11:0]         torque_q, torque_d;
    logic                conv_vld_q, conv_vld_d;
    logic [1:0]          ch_id_q, ch_id_d;
    logic                overrun_q, overrun_d;

    // Slots are dense 0..3 but the A2D mux skips channel 2.
    function automatic logic [2:0] slot_to_ch(input logic [1:0] slot);
        case (slot)
            2'd0:    slot_to_ch = 3'd0;
            2'd1:    slot_to_ch = 3'd1;
            2'd2:    slot_to_ch = 3'd3;
            default: slot_to_ch = 3'd4;
        endcase
    endfunction

    assign tick = &cnt_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        snd_d      = 1'b0;
        cmd_d      = cmd_q;
        batt_d     = batt_q;
        curr_d     = curr_q;
        brake_d    = brake_q;
        torque_d   = torque_q;
        conv_vld_d = 1'b0;
        ch_id_d    = ch_id_q;
        overrun_d  = tick && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (tick) begin
                    snd_d   = 1'b1;
                    cmd_d   = {2'b00, slot_to_ch(ptr_q), 11'h000};
                    state_d = CMD;
                end
            end
            CMD: begin
                // First response is stale (previous mux setting); re-issue the same command.
                if (done) begin
                    snd_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = READ;
            end
            READ: begin
                if (done) begin
                    case (ptr_q)
                        2'd0:    batt_d   = resp[11:0];
                        2'd1:    curr_d   = resp[11:0];
                        2'd2:    brake_d  = resp[11:0];
                        default: torque_d = resp[11:0];
                    endcase
                    conv_vld_d = 1'b1;
                    ch_id_d    = ptr_q;
                    ptr_d      = ptr_q + 2'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= 2'd0;
            snd_q      <= 1'b0;
            cmd_q      <= 16'h0000;
            batt_q     <= 12'h000;
            curr_q     <= 12'h000;
            brake_q    <= 12'h000;
            torque_q   <= 12'h000;
            conv_vld_q <= 1'b0;
            ch_id_q    <= 2'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_q + 1'b1;
            ptr_q      <= ptr_d;
            snd_q      <= snd_d;
            cmd_q      <= cmd_d;
            batt_q     <= batt_d;
            curr_q     <= curr_d;
            brake_q    <= brake_d;
            torque_q   <= torque_d;
            conv_vld_q <= conv_vld_d;
            ch_id_q    <= ch_id_d;
            overrun_q  <= overrun_d;
        end
    end

    assign snd      = snd_q;
    assign cmd      = cmd_q;
    assign batt     = batt_q;
    assign curr     = curr_q;
    assign brake    = brake_q;
    assign torque   = torque_q;
    assign conv_vld = conv_vld_q;
    assign ch_id    = ch_id_q;
    assign overrun  = overrun_q;

endmodule
